// File: rtl/mmio_pkg.sv
// Shared types and constants for the memory-stage MMIO bridge.
package mmio_pkg;

  // Bridge transaction states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address-space classification of the EX_DM address.
  typedef enum logic [1:0] {
    DM       = 2'd0,
    IO       = 2'd1,
    UNMAPPED = 2'd2
  } region_t;

  // Returned for unmapped loads, load+store collisions and timed-out loads.
  localparam logic [15:0] DEAD_WORD = 16'hDEAD;

  // Width of a channel index; a single channel still needs one bit of storage.
  function automatic int unsigned ch_index_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mmio_decode.sv
// Combinational address decoder: region, channel index and register offset.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       NUM_CH       = 4,
  parameter int unsigned       CH_SPAN_BITS = 4,
  parameter logic [ADDR_W-1:0] DM_LIMIT     = 16'h2000,
  parameter logic [ADDR_W-1:0] IO_BASE      = 16'hC000,
  parameter int unsigned       CH_W         = 2
) (
  input  logic [ADDR_W-1:0]       i_addr,
  output region_t                 o_region,
  output logic [CH_W-1:0]         o_ch,
  output logic [CH_SPAN_BITS-1:0] o_offset
);

  // One extra bit so the end of the I/O window cannot wrap past the top of
  // the address space and silently shrink the window.
  localparam int unsigned      EXT_W = ADDR_W + 1;
  localparam logic [EXT_W-1:0] DM_HI = {1'b0, DM_LIMIT};
  localparam logic [EXT_W-1:0] IO_LO = {1'b0, IO_BASE};
  localparam logic [EXT_W-1:0] IO_HI = IO_LO + (EXT_W'(NUM_CH) << CH_SPAN_BITS);

  logic [EXT_W-1:0]  w_addr_x;
  logic [ADDR_W-1:0] w_rel;

  assign w_addr_x = {1'b0, i_addr};
  assign w_rel    = i_addr - IO_BASE;

  // Classify the address; anything outside DM and the channel window is unmapped.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    o_region = UNMAPPED;
    if (w_addr_x < DM_HI) begin
      o_region = DM;
    end else if ((w_addr_x >= IO_LO) && (w_addr_x < IO_HI)) begin
      o_region = IO;
    end
  end

  // Channel index counts whole spans above the window base; offset is the low bits.
  assign o_ch     = CH_W'(w_rel >> CH_SPAN_BITS);
  assign o_offset = i_addr[CH_SPAN_BITS-1:0];

endmodule

// File: rtl/mmio_bridge.sv
// Memory-stage bus bridge: routes CPU loads/stores to data memory or to one of
// NUM_CH waited peripheral channels, stalling the pipe during channel accesses.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 16,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       NUM_CH       = 4,
  parameter logic [ADDR_W-1:0] DM_LIMIT     = 16'h2000,
  parameter logic [ADDR_W-1:0] IO_BASE      = 16'hC000,
  parameter int unsigned       CH_SPAN_BITS = 4,
  parameter int unsigned       TIMEOUT      = 15,
  localparam int unsigned      CH_W         = ch_index_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_stall,
  output logic                     dm_we,
  input  logic [DATA_W-1:0]        dm_rdata,
  output logic [NUM_CH-1:0]        ch_req,
  output logic                     ch_we,
  output logic [CH_SPAN_BITS-1:0]  ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ack,
  input  logic                     err_clr,
  output logic                     err_timeout,
  output logic [CH_W-1:0]          err_ch
);

  localparam int unsigned      CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] DEAD = DATA_W'(DEAD_WORD);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);

  // Decoder results for the current EX_DM address.
  region_t                 w_region;
  logic [CH_W-1:0]         w_ch;
  logic [CH_SPAN_BITS-1:0] w_offset;
  logic                    w_io_access;

  // Response of the channel latched for the transaction in flight.
  logic                    w_sel_ack;
  logic [DATA_W-1:0]       w_sel_rdata;
  logic [DATA_W-1:0]       w_cpu_rdata;

  // Transaction state and latched request fields.
  state_t                  r_state;
  logic [CH_W-1:0]         r_ch;
  logic [NUM_CH-1:0]       r_ch_req;
  logic                    r_ch_we;
  logic [CH_SPAN_BITS-1:0] r_ch_addr;
  logic [DATA_W-1:0]       r_ch_wdata;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_W-1:0]       r_rdata_q;
  logic                    r_err_timeout;
  logic [CH_W-1:0]         r_err_ch;

  mmio_decode #(
    .ADDR_W       (ADDR_W),
    .NUM_CH       (NUM_CH),
    .CH_SPAN_BITS (CH_SPAN_BITS),
    .DM_LIMIT     (DM_LIMIT),
    .IO_BASE      (IO_BASE),
    .CH_W         (CH_W)
  ) u_decode (
    .i_addr   (cpu_addr),
    .o_region (w_region),
    .o_ch     (w_ch),
    .o_offset (w_offset)
  );

  assign w_io_access = (w_region == IO) && (cpu_re || cpu_we);

  // Pick ack and read data of the channel that owns the current transaction;
  // acks from every other channel are simply never looked at.
  always_comb begin
    w_sel_ack   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == CH_W'(i)) begin
        w_sel_ack   = ch_ack[i];
        w_sel_rdata = ch_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Load data: finished channel result in DONE, DM data for plain DM loads,
  // otherwise the poison word (unmapped, load+store collision, idle I/O).
  always_comb begin
    w_cpu_rdata = DEAD;
    if (r_state == DONE) begin
      w_cpu_rdata = r_rdata_q;
    end else if ((w_region == DM) && !cpu_we) begin
      w_cpu_rdata = dm_rdata;
    end
  end

  // Transaction FSM with latched request fields, wait counter and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ch          <= '0;
      r_ch_req      <= '0;
      r_ch_we       <= 1'b0;
      r_ch_addr     <= '0;
      r_ch_wdata    <= '0;
      r_cnt         <= '0;
      r_rdata_q     <= '0;
      r_err_timeout <= 1'b0;
      r_err_ch      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees pre-edge values; a later assignment in this block overrides an
      // earlier one, which is how a timeout beats a same-cycle err_clr below.
      if (err_clr) begin
        r_err_timeout <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_io_access) begin
            r_ch       <= w_ch;
            r_ch_req   <= NUM_CH'(1) << w_ch;
            r_ch_we    <= cpu_we;
            r_ch_addr  <= w_offset;
            r_ch_wdata <= cpu_wdata;
            // The counter holds the number of REQ cycles including the current one.
            r_cnt      <= CNT_W'(1);
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (w_sel_ack) begin
            if (!r_ch_we) begin
              r_rdata_q <= w_sel_rdata;
            end
            r_ch_req <= '0;
            r_state  <= DONE;
          end else if (r_cnt == CNT_LIMIT) begin
            r_rdata_q     <= DEAD;
            r_err_timeout <= 1'b1;
            r_err_ch      <= r_ch;
            r_ch_req      <= '0;
            r_state       <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // The pipe advances this cycle, so the request still on the inputs is
          // the one just completed; returning to IDLE never re-issues it.
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_ch_req <= '0;
          r_cnt    <= '0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  // Stall covers the decode cycle of an I/O access plus every REQ cycle.
  assign cpu_stall   = (r_state == REQ) || ((r_state == IDLE) && w_io_access);
  assign dm_we       = cpu_we && (w_region == DM);
  assign cpu_rdata   = w_cpu_rdata;
  assign ch_req      = r_ch_req;
  assign ch_we       = r_ch_we;
  assign ch_addr     = r_ch_addr;
  assign ch_wdata    = r_ch_wdata;
  assign err_timeout = r_err_timeout;
  assign err_ch      = r_err_ch;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge with default parameters.
module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        dm_we;
  logic [15:0] dm_rdata;
  logic [3:0]  ch_req;
  logic        ch_we;
  logic [3:0]  ch_addr;
  logic [15:0] ch_wdata;
  logic [63:0] ch_rdata;
  logic [3:0]  ch_ack;
  logic        err_clr;
  logic        err_timeout;
  logic [1:0]  err_ch;

  int n_vec  = 0;
  int n_miss = 0;

  // Observations gathered by run_io for the calling test to compare.
  int          stalls;
  int          reqc;
  bit          fok;
  bit          fin;
  logic [15:0] drd;
  logic        derr;
  logic [1:0]  dech;
  logic [3:0]  dreq;
  logic [3:0]  first_req;
  logic        pstall;
  logic [3:0]  preq;

  mmio_bridge #(
    .ADDR_W (16), .DATA_W (16), .NUM_CH (4), .DM_LIMIT (16'h2000),
    .IO_BASE (16'hC000), .CH_SPAN_BITS (4), .TIMEOUT (15)
  ) dut (
    .clk (clk), .rst (rst), .cpu_addr (cpu_addr), .cpu_re (cpu_re),
    .cpu_we (cpu_we), .cpu_wdata (cpu_wdata), .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall), .dm_we (dm_we), .dm_rdata (dm_rdata),
    .ch_req (ch_req), .ch_we (ch_we), .ch_addr (ch_addr), .ch_wdata (ch_wdata),
    .ch_rdata (ch_rdata), .ch_ack (ch_ack), .err_clr (err_clr),
    .err_timeout (err_timeout), .err_ch (err_ch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge; inputs change here,
  // outputs are sampled 4 units later at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one I/O access and records what the bridge did, cycle by cycle.
  // Cycle 0 is the decode cycle; REQ cycle k is loop cycle k.
  task automatic run_io(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                        input int tgt, input int ack_at, input logic [15:0] ack_data,
                        input logic [3:0] foreign, input int clr_at);
    bit done;
    stalls = 0; reqc = 0; fok = 1'b1; fin = 1'b0; first_req = '0;
    drd = '0; derr = 1'b0; dech = '0; dreq = 'x;
    for (int i = 0; i < 4; i++) ch_rdata[i*16 +: 16] = (i == tgt) ? ack_data : 16'h7777;
    cpu_addr = addr; cpu_we = we; cpu_re = !we; cpu_wdata = wdata;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      ch_ack = foreign;
      if (ack_at != 0 && c == ack_at) ch_ack[tgt] = 1'b1;
      err_clr = (c == clr_at);
      if (c > 0) cpu_wdata = ~wdata;
      #4;
      if (cpu_stall === 1'b1) begin
        stalls++;
        if (c > 0) begin
          if (ch_req !== 4'b0) reqc++;
          if (c == 1) first_req = ch_req;
          else if (ch_req !== first_req) fok = 1'b0;
          if (ch_we !== we || ch_addr !== addr[3:0] || ch_wdata !== wdata) fok = 1'b0;
        end
      end else begin
        done = 1'b1; fin = 1'b1;
        drd = cpu_rdata; derr = err_timeout; dech = err_ch; dreq = ch_req;
      end
      step();
    end
    cpu_re = 1'b0; cpu_we = 1'b0; ch_ack = '0; err_clr = 1'b0; cpu_wdata = '0;
    #4;
    pstall = cpu_stall; preq = ch_req;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    dm_rdata = '0; ch_rdata = '0; ch_ack = '0; err_clr = 1'b0;
    step(); step();
    #4;
    n_vec++; if (ch_req !== 4'b0000) begin n_miss++; $display("FAIL reset_ch_req: got %b want 0000", ch_req); end
    n_vec++; if (cpu_stall !== 1'b0) begin n_miss++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
    n_vec++; if ({ch_we, ch_addr, ch_wdata} !== 21'd0) begin n_miss++; $display("FAIL reset_ch_fields: got we=%b addr=%h wdata=%h want 0", ch_we, ch_addr, ch_wdata); end
    n_vec++; if (err_timeout !== 1'b0 || err_ch !== 2'd0) begin n_miss++; $display("FAIL reset_err: got %b/%0d want 0/0", err_timeout, err_ch); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_dm();
    cpu_addr = 16'h0100; cpu_we = 1'b1; cpu_wdata = 16'h55AA; #4;
    n_vec++; if (dm_we !== 1'b1) begin n_miss++; $display("FAIL dm_store_we: got %b want 1", dm_we); end
    n_vec++; if (cpu_stall !== 1'b0) begin n_miss++; $display("FAIL dm_store_stall: got %b want 0", cpu_stall); end
    step();
    cpu_we = 1'b0; cpu_re = 1'b1; dm_rdata = 16'hBEEF; #4;
    n_vec++; if (cpu_rdata !== 16'hBEEF) begin n_miss++; $display("FAIL dm_load_data: got %h want beef", cpu_rdata); end
    n_vec++; if (dm_we !== 1'b0 || cpu_stall !== 1'b0) begin n_miss++; $display("FAIL dm_load_ctl: got we=%b stall=%b want 0/0", dm_we, cpu_stall); end
    step();
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h1FFF; #4;
    n_vec++; if (dm_we !== 1'b1) begin n_miss++; $display("FAIL dm_top_edge: got %b want 1", dm_we); end
    step();
    cpu_addr = 16'h2000; #4;
    n_vec++; if (dm_we !== 1'b0 || cpu_stall !== 1'b0) begin n_miss++; $display("FAIL dm_limit_edge: got we=%b stall=%b want 0/0", dm_we, cpu_stall); end
    step();
    cpu_addr = 16'h0100; cpu_re = 1'b1; cpu_we = 1'b1; #4;
    n_vec++; if (cpu_rdata !== 16'hDEAD || dm_we !== 1'b1) begin n_miss++; $display("FAIL dm_re_we: got rdata=%h we=%b want dead/1", cpu_rdata, dm_we); end
    step();
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_unmapped();
    logic [15:0] addrs [4] = '{16'h8000, 16'hC040, 16'hBFFF, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      cpu_addr = addrs[i]; cpu_re = 1'b1; cpu_we = 1'b0; dm_rdata = 16'h1111; #4;
      n_vec++; if (cpu_rdata !== 16'hDEAD || cpu_stall !== 1'b0) begin n_miss++; $display("FAIL unmapped_load %h: got rdata=%h stall=%b want dead/0", addrs[i], cpu_rdata, cpu_stall); end
      step();
      cpu_re = 1'b0; cpu_we = 1'b1; #4;
      n_vec++; if (dm_we !== 1'b0 || ch_req !== 4'b0 || cpu_stall !== 1'b0) begin n_miss++; $display("FAIL unmapped_store %h: got dm_we=%b req=%b stall=%b want 0/0000/0", addrs[i], dm_we, ch_req, cpu_stall); end
      step();
      cpu_we = 1'b0;
    end
  endtask

  task automatic test_io_read();
    run_io(16'hC011, 1'b0, 16'h0000, 1, 3, 16'h1234, 4'b0000, -1);
    n_vec++; if (fin !== 1'b1) begin n_miss++; $display("FAIL io_read_done: got %b want 1 (no DONE within budget)", fin); end
    n_vec++; if (stalls !== 4) begin n_miss++; $display("FAIL io_read_stalls: got %0d want 4", stalls); end
    n_vec++; if (first_req !== 4'b0010 || reqc !== 3) begin n_miss++; $display("FAIL io_read_req: got %b x%0d want 0010 x3", first_req, reqc); end
    n_vec++; if (fok !== 1'b1) begin n_miss++; $display("FAIL io_read_fields: got %b want 1", fok); end
    n_vec++; if (drd !== 16'h1234 || dreq !== 4'b0) begin n_miss++; $display("FAIL io_read_data: got %h req=%b want 1234/0000", drd, dreq); end
    n_vec++; if (pstall !== 1'b0 || preq !== 4'b0) begin n_miss++; $display("FAIL io_read_reissue: got stall=%b req=%b want 0/0000", pstall, preq); end
  endtask

  task automatic test_io_write();
    run_io(16'hC03A, 1'b1, 16'h5A5A, 3, 1, 16'h9999, 4'b0000, -1);
    n_vec++; if (stalls !== 2 || first_req !== 4'b1000) begin n_miss++; $display("FAIL io_write_req: got stalls=%0d req=%b want 2/1000", stalls, first_req); end
    n_vec++; if (fok !== 1'b1) begin n_miss++; $display("FAIL io_write_fields: got %b want 1", fok); end
    n_vec++; if (drd !== 16'h1234) begin n_miss++; $display("FAIL io_write_rdata_kept: got %h want 1234", drd); end
  endtask

  task automatic test_ack_at_limit();
    run_io(16'hC005, 1'b0, 16'h0000, 0, 15, 16'hA5C3, 4'b0010, -1);
    n_vec++; if (stalls !== 16 || reqc !== 15) begin n_miss++; $display("FAIL limit_ack_len: got stalls=%0d req=%0d want 16/15", stalls, reqc); end
    n_vec++; if (drd !== 16'hA5C3 || derr !== 1'b0) begin n_miss++; $display("FAIL limit_ack_data: got %h err=%b want a5c3/0", drd, derr); end
  endtask

  task automatic test_timeout();
    run_io(16'hC020, 1'b1, 16'h0BAD, 2, 0, 16'h0000, 4'b0000, -1);
    n_vec++; if (first_req !== 4'b0100 || reqc !== 15 || stalls !== 16) begin n_miss++; $display("FAIL timeout_req: got %b x%0d stalls=%0d want 0100 x15 / 16", first_req, reqc, stalls); end
    n_vec++; if (derr !== 1'b1 || dech !== 2'd2) begin n_miss++; $display("FAIL timeout_err: got %b ch=%0d want 1 ch=2", derr, dech); end
    n_vec++; if (drd !== 16'hDEAD) begin n_miss++; $display("FAIL timeout_rdata: got %h want dead", drd); end
    #4;
    n_vec++; if (err_timeout !== 1'b1) begin n_miss++; $display("FAIL timeout_sticky: got %b want 1", err_timeout); end
    step();
    err_clr = 1'b1; step(); err_clr = 1'b0; #4;
    n_vec++; if (err_timeout !== 1'b0) begin n_miss++; $display("FAIL timeout_clr: got %b want 0", err_timeout); end
    step();
  endtask

  task automatic test_set_wins();
    run_io(16'hC03F, 1'b0, 16'h0000, 3, 0, 16'h0000, 4'b0000, 15);
    n_vec++; if (derr !== 1'b1 || dech !== 2'd3) begin n_miss++; $display("FAIL set_wins: got %b ch=%0d want 1 ch=3", derr, dech); end
    n_vec++; if (fok !== 1'b1 || drd !== 16'hDEAD) begin n_miss++; $display("FAIL set_wins_fields: got ok=%b rdata=%h want 1/dead", fok, drd); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_req();
    for (int i = 0; i < 4; i++) ch_rdata[i*16 +: 16] = 16'h7777;
    cpu_addr = 16'hC011; cpu_re = 1'b1; cpu_we = 1'b0; #4;
    step(); #4;
    n_vec++; if (ch_req !== 4'b0010) begin n_miss++; $display("FAIL rst_mid_pre: got %b want 0010", ch_req); end
    step();
    rst = 1'b1; cpu_re = 1'b0; #4;
    step();
    rst = 1'b0; #4;
    n_vec++; if (ch_req !== 4'b0 || cpu_stall !== 1'b0 || err_timeout !== 1'b0) begin n_miss++; $display("FAIL rst_mid_post: got req=%b stall=%b err=%b want 0000/0/0", ch_req, cpu_stall, err_timeout); end
    step();
  endtask

  task automatic test_back_to_back();
    run_io(16'hC00C, 1'b1, 16'hCAFE, 0, 1, 16'h4444, 4'b0000, -1);
    n_vec++; if (stalls !== 2 || drd !== 16'h0000) begin n_miss++; $display("FAIL post_rst_write: got stalls=%0d rdata=%h want 2/0000", stalls, drd); end
    run_io(16'hC011, 1'b0, 16'h0000, 1, 2, 16'h0F0F, 4'b0000, -1);
    n_vec++; if (stalls !== 3 || drd !== 16'h0F0F || first_req !== 4'b0010) begin n_miss++; $display("FAIL post_rst_read: got stalls=%0d rdata=%h req=%b want 3/0f0f/0010", stalls, drd, first_req); end
    n_vec++; if (derr !== 1'b0 || pstall !== 1'b0) begin n_miss++; $display("FAIL post_rst_clean: got err=%b stall=%b want 0/0", derr, pstall); end
  endtask

  initial begin
    test_reset();
    test_dm();
    test_unmapped();
    test_io_read();
    test_io_write();
    test_ack_at_limit();
    test_timeout();
    test_set_wins();
    test_reset_mid_req();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
